vending_controller_multi: RTL and testbench

- Parametrised next-generation vending controller; replaces the single-shot amount-in / change-out machine.
- Coins arrive one per cycle and accumulate as credit; the item count is a parameter.
- Prices live in a run-time programmable table.
- Change is paid out greedily, one coin per cycle, through a small FSM.
- Sits between the coin acceptor front end and the dispenser/coin-hopper drivers.

---
 rtl/vending_controller_multi.sv | 211 +++++++++++++++++++++
 tb/tb_vending_controller_multi.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_controller_multi.sv
// Multi-item vending controller: coin credit, programmable price table, greedy change FSM.
// Optional per-item stock counters enabled by defining VEND_STOCK_EN.
module vending_controller_multi #(
  parameter int unsigned NUM_ITEMS     = 8,
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned CREDIT_W      = 9,
  parameter int unsigned MAX_CREDIT    = 300,
  parameter int unsigned DEFAULT_PRICE = 100,
  parameter int unsigned STOCK_W       = 4,
  parameter int unsigned INIT_STOCK    = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  output logic                coin_reject,
  input  logic                select_valid,
  input  logic [SEL_W-1:0]    select,
  input  logic                cancel,
  input  logic                price_wr,
  input  logic [SEL_W-1:0]    price_addr,
  input  logic [CREDIT_W-1:0] price_data,
  input  logic                stock_wr,
  input  logic [STOCK_W-1:0]  stock_data,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                item_valid,
  output logic [SEL_W-1:0]    item_id,
  output logic                status_valid,
  output logic [1:0]          status_code,
  output logic                chg_valid,
  output logic [1:0]          chg_type
);

  localparam int unsigned DEPTH     = 1 << SEL_W;
  localparam int unsigned SEL_W1    = SEL_W + 1;
  localparam int unsigned CREDIT_W1 = CREDIT_W + 1;
  localparam logic [SEL_W:0]    ITEMS_L = SEL_W1'(NUM_ITEMS);
  localparam logic [CREDIT_W:0] MAX_L   = CREDIT_W1'(MAX_CREDIT);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t              state, state_d;
  logic [CREDIT_W-1:0] remain, remain_d, credit_d;
  logic [CREDIT_W-1:0] price [DEPTH];
  logic [CREDIT_W-1:0] sel_price, emit_amt;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_reject_d, item_valid_d, status_valid_d, chg_valid_d;
  logic [SEL_W-1:0]    item_id_d;
  logic [1:0]          status_code_d, chg_type_d;
  logic                sel_in_range, wr_in_range, sold_out, vend_ok, emit, price_we;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
    logic [CREDIT_W-1:0] v;
    case (t)
      2'd0:    v = CREDIT_W'(5);
      2'd1:    v = CREDIT_W'(10);
      2'd2:    v = CREDIT_W'(25);
      default: v = CREDIT_W'(100);
    endcase
    return v;
  endfunction

  // Largest coin not exceeding the amount still owed.
  function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] amt);
    logic [1:0] t;
    if (amt >= CREDIT_W'(100))     t = 2'd3;
    else if (amt >= CREDIT_W'(25)) t = 2'd2;
    else if (amt >= CREDIT_W'(10)) t = 2'd1;
    else                           t = 2'd0;
    return t;
  endfunction

  function automatic logic [CREDIT_W-1:0] pay_out(input logic [CREDIT_W-1:0] amt,
                                                  input logic [1:0] t);
    return (amt > coin_value(t)) ? amt - coin_value(t) : '0;
  endfunction

  assign sel_in_range = {1'b0, select} < ITEMS_L;
  assign wr_in_range  = {1'b0, price_addr} < ITEMS_L;
  assign sel_price    = price[select];
  assign coin_sum     = {1'b0, credit} + {1'b0, coin_value(coin_type)};
  assign price_we     = (state == IDLE) && price_wr && wr_in_range;

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0] stock [DEPTH];

  assign sold_out = (stock[select] == '0);

  // Explicit load wins over a same-cycle decrement; an empty counter never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else if ((state == IDLE) && stock_wr && wr_in_range) begin
      stock[price_addr] <= stock_data;
    end else if (vend_ok && (stock[select] != '0)) begin
      stock[select] <= stock[select] - STOCK_W'(1);
    end
  end
`else
  localparam int unsigned unused_init_stock = INIT_STOCK;
  logic unused_stock;
  assign sold_out     = 1'b0;
  assign unused_stock = ^{stock_wr, stock_data, vend_ok};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) price[i] <= CREDIT_W'(DEFAULT_PRICE);
    end else if (price_we) begin
      price[price_addr] <= price_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      remain       <= '0;
      busy         <= 1'b0;
      coin_reject  <= 1'b0;
      item_valid   <= 1'b0;
      item_id      <= '0;
      status_valid <= 1'b0;
      status_code  <= '0;
      chg_valid    <= 1'b0;
      chg_type     <= '0;
    end else begin
      state        <= state_d;
      credit       <= credit_d;
      remain       <= remain_d;
      busy         <= (state_d != IDLE);
      coin_reject  <= coin_reject_d;
      item_valid   <= item_valid_d;
      item_id      <= item_id_d;
      status_valid <= status_valid_d;
      status_code  <= status_code_d;
      chg_valid    <= chg_valid_d;
      chg_type     <= chg_type_d;
    end
  end

  // Next state: IDLE priority cancel > select > coin; each change coin is issued on entering its cycle.
  always_comb begin
    state_d        = state;
    credit_d       = credit;
    remain_d       = remain;
    coin_reject_d  = 1'b0;
    item_valid_d   = 1'b0;
    item_id_d      = item_id;
    status_valid_d = 1'b0;
    status_code_d  = status_code;
    chg_valid_d    = 1'b0;
    chg_type_d     = chg_type;
    vend_ok        = 1'b0;
    emit           = 1'b0;
    emit_amt       = remain;
    case (state)
      IDLE: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          if (credit != '0) begin
            emit     = 1'b1;
            emit_amt = credit;
            credit_d = '0;
            state_d  = CHANGE;
          end
        end else if (select_valid) begin
          coin_reject_d  = coin_valid;
          status_valid_d = 1'b1;
          if (!sel_in_range)          status_code_d = 2'd2;
          else if (sold_out)          status_code_d = 2'd3;
          else if (credit < sel_price) status_code_d = 2'd1;
          else begin
            status_code_d = 2'd0;
            vend_ok       = 1'b1;
            item_valid_d  = 1'b1;
            item_id_d     = select;
            remain_d      = credit - sel_price;
            credit_d      = '0;
            state_d       = VEND;
          end
        end else if (coin_valid) begin
          if (coin_sum <= MAX_L) credit_d = coin_sum[CREDIT_W-1:0];
          else                   coin_reject_d = 1'b1;
        end
      end
      VEND: begin
        coin_reject_d = coin_valid;
        if (remain != '0) begin
          emit    = 1'b1;
          state_d = CHANGE;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (remain != '0) emit = 1'b1;
        else              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (emit) begin
      chg_valid_d = 1'b1;
      chg_type_d  = pick_coin(emit_amt);
      remain_d    = pay_out(emit_amt, chg_type_d);
    end
  end

endmodule

// File: tb/tb_vending_controller_multi.sv
// Bench for vending_controller_multi: directed scenarios plus random traffic against a
// transaction-level model (credit total, price/stock arrays, queue of owed change coins).
module tb_vending_controller_multi;

  localparam int NI = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_reject;
  logic       select_valid;
  logic [2:0] select;
  logic       cancel;
  logic       price_wr;
  logic [2:0] price_addr;
  logic [8:0] price_data;
  logic       stock_wr;
  logic [3:0] stock_data;
  logic [8:0] credit;
  logic       busy;
  logic       item_valid;
  logic [2:0] item_id;
  logic       status_valid;
  logic [1:0] status_code;
  logic       chg_valid;
  logic [1:0] chg_type;

  vending_controller_multi #(.NUM_ITEMS(NI)) dut (
    .clock(clock), .reset(reset),
    .coin_valid(coin_valid), .coin_type(coin_type), .coin_reject(coin_reject),
    .select_valid(select_valid), .select(select), .cancel(cancel),
    .price_wr(price_wr), .price_addr(price_addr), .price_data(price_data),
    .stock_wr(stock_wr), .stock_data(stock_data),
    .credit(credit), .busy(busy), .item_valid(item_valid), .item_id(item_id),
    .status_valid(status_valid), .status_code(status_code),
    .chg_valid(chg_valid), .chg_type(chg_type)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int coin_val [4] = '{5, 10, 25, 100};
  int m_price [8];
  int m_stock [8];
  int m_credit, m_code, m_item_id;
  bit m_vend, m_reject, m_item, m_status;
  int chg_q [$];
  int pend_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic make_change(input int amt);
    int a;
    a = amt;
    pend_q.delete();
    while (a > 0) begin
      if (a >= 100)     begin pend_q.push_back(3); a -= 100; end
      else if (a >= 25) begin pend_q.push_back(2); a -= 25;  end
      else if (a >= 10) begin pend_q.push_back(1); a -= 10;  end
      else              begin pend_q.push_back(0); a -= 5;   end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_price[i] = 100;
      m_stock[i] = 10;
    end
    m_credit = 0; m_code = 0; m_item_id = 0;
    m_vend = 0; m_reject = 0; m_item = 0; m_status = 0;
    chg_q.delete();
    pend_q.delete();
  endtask

  // Advances the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int v;
    m_reject = 0; m_item = 0; m_status = 0;
    if (reset) begin
      model_reset();
    end else if (!m_vend && chg_q.size() == 0) begin
      if (cancel) begin
        m_reject = coin_valid;
        if (m_credit != 0) begin
          make_change(m_credit);
          chg_q = pend_q;
          pend_q.delete();
          m_credit = 0;
        end
      end else if (select_valid) begin
        m_status = 1;
        m_reject = coin_valid;
        if (int'(select) >= NI) m_code = 2;
`ifdef VEND_STOCK_EN
        else if (m_stock[select] == 0) m_code = 3;
`endif
        else if (m_credit < m_price[select]) m_code = 1;
        else begin
          m_code = 0;
          m_item = 1;
          m_item_id = int'(select);
          make_change(m_credit - m_price[select]);
          m_credit = 0;
          m_vend = 1;
          if (m_stock[select] > 0) m_stock[select]--;
        end
      end else if (coin_valid) begin
        v = coin_val[coin_type];
        if (m_credit + v <= 300) m_credit += v;
        else m_reject = 1;
      end
      if (price_wr && int'(price_addr) < NI) m_price[price_addr] = int'(price_data);
      if (stock_wr && int'(price_addr) < NI) m_stock[price_addr] = int'(stock_data);
    end else if (m_vend) begin
      m_reject = coin_valid;
      m_vend = 0;
      chg_q = pend_q;
      pend_q.delete();
    end else begin
      m_reject = coin_valid;
      void'(chg_q.pop_front());
    end
  endtask

  task automatic compare_all();
    bit exp_chg;
    exp_chg = !m_vend && chg_q.size() != 0;
    check("credit", 32'(credit), 32'(m_credit));
    check("busy", 32'(busy), 32'(m_vend || chg_q.size() != 0));
    check("item_valid", 32'(item_valid), 32'(m_item));
    check("item_id", 32'(item_id), 32'(m_item_id));
    check("status_valid", 32'(status_valid), 32'(m_status));
    if (m_status) check("status_code", 32'(status_code), 32'(m_code));
    check("chg_valid", 32'(chg_valid), 32'(exp_chg));
    if (exp_chg) check("chg_type", 32'(chg_type), 32'(chg_q[0]));
    check("coin_reject", 32'(coin_reject), 32'(m_reject));
  endtask

  task automatic clear_inputs();
    coin_valid = 0; coin_type = 0; select_valid = 0; select = 0; cancel = 0;
    price_wr = 0; price_addr = 0; price_data = 0; stock_wr = 0; stock_data = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
    clear_inputs();
  endtask

  task automatic put_coin(input int t);
    coin_valid = 1; coin_type = 2'(t); tick();
  endtask

  task automatic pick(input int s);
    select_valid = 1; select = 3'(s); tick();
  endtask

  task automatic do_cancel();
    cancel = 1; tick();
  endtask

  task automatic wr_price(input int a, input int d);
    price_wr = 1; price_addr = 3'(a); price_data = 9'(d); tick();
  endtask

  task automatic wr_stock(input int a, input int d);
    stock_wr = 1; price_addr = 3'(a); stock_data = 4'(d); tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;

    // Four quarters then a 100-cent item with exact credit
    for (int i = 0; i < 4; i++) put_coin(2);
    check("plan_credit_100", 32'(credit), 32'd100);
    pick(2);
    check("plan_item_id", 32'(item_id), 32'd2);
    idle(3);

    // 85-cent item from a dollar: dime then nickel
    wr_price(1, 85);
    put_coin(3);
    pick(1);
    idle(4);

    // Credit ceiling, rejected nickel, then full refund
    for (int i = 0; i < 3; i++) put_coin(3);
    put_coin(0);
    check("plan_ceiling_reject", 32'(coin_reject), 32'd1);
    do_cancel();
    idle(4);

    // Insufficient credit and invalid index
    put_coin(2); put_coin(2);
    pick(1);
    pick(7);
    check("plan_invalid_idx", 32'(status_code), 32'd2);
    check("plan_credit_kept", 32'(credit), 32'd50);
    do_cancel();
    idle(3);

    // Long change burst disturbed by a coin and a select, then reset mid-burst
    wr_price(3, 5);
    put_coin(3); put_coin(3);
    pick(3);
    idle(1);
    coin_valid = 1; coin_type = 1; select_valid = 1; select = 0; tick();
    idle(1);
    reset = 1; tick(); reset = 0;
    tick();
    put_coin(3);
    pick(1);
    idle(3);

    // Stock: one unit of item 0
    wr_stock(0, 1);
    put_coin(3); put_coin(3);
    pick(0);
    idle(3);
    put_coin(3);
    pick(0);
`ifdef VEND_STOCK_EN
    check("plan_sold_out", 32'(status_code), 32'd3);
`else
    check("plan_no_stock", 32'(status_code), 32'd0);
`endif
    idle(3);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      coin_valid   = ($urandom_range(0, 99) < 40);
      coin_type    = 2'($urandom_range(0, 3));
      select_valid = ($urandom_range(0, 99) < 15);
      select       = 3'($urandom_range(0, 7));
      cancel       = ($urandom_range(0, 99) < 4);
      price_wr     = ($urandom_range(0, 99) < 6);
      price_addr   = 3'($urandom_range(0, 7));
      price_data   = 9'($urandom_range(0, 30) * 5);
      stock_wr     = ($urandom_range(0, 99) < 4);
      stock_data   = 4'($urandom_range(0, 3));
      reset        = ($urandom_range(0, 199) == 0);
      tick();
      reset = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
